// File: rtl/byte_serial_adder_ctrl_pkg.sv
// Shared constants for the byte-serial adder controller: byte width and FSM encoding.
package byte_serial_adder_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serial_adder_ctrl_byte_adder_8.sv
// byte_adder_8: combinational 8-bit adder with carry in/out, shared across all byte positions.
module byte_adder_8
  import byte_serial_adder_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  // Single ripple add; the widened sum exposes the carry out of bit 7.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// byte_serial_adder_ctrl: wide A+B+cin computed one byte per cycle (LSB first) on one
// shared 8-bit adder, with valid/ready handshakes on operands and result.
// Optional macro SUB_MODE_EN adds an in_sub port selecting A-B (out_cout=1 means no borrow).
module byte_serial_adder_ctrl
  import byte_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_a,
  input  logic [BYTE_W*NBYTES-1:0] in_b,
  input  logic                     in_cin,
`ifdef SUB_MODE_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int unsigned W        = BYTE_W * NBYTES;
  localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;

  logic [W-1:0]      load_b;
  logic              load_cin;
  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;

  // Operand conditioning at accept time: subtraction is A + ~B + 1.
`ifdef SUB_MODE_EN
  assign load_b   = in_sub ? ~in_b : in_b;
  assign load_cin = in_sub ? 1'b1  : in_cin;
`else
  assign load_b   = in_b;
  assign load_cin = in_cin;
`endif

  // Select the current byte of each operand for the shared adder.
  assign add_a = op_a[idx*BYTE_W +: BYTE_W];
  assign add_b = op_b[idx*BYTE_W +: BYTE_W];

  byte_adder_8 u_byte_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Controller: operand capture, byte sequencing with registered carry, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= load_b;
            carry    <= load_cin;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          out_sum[idx*BYTE_W +: BYTE_W] <= add_sum;
          carry <= add_cout;
          if (idx == IDX_LAST) begin
            idx       <= '0;
            out_cout  <= add_cout;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Self-checking bench for byte_serial_adder_ctrl (NBYTES=4); honours SUB_MODE_EN.
module tb_byte_serial_adder_ctrl;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef SUB_MODE_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  byte_serial_adder_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SUB_MODE_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  res_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference: (A + B + cin) or (A + ~B + 1) over W+1 bits.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         c;
    res_t         r;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    return r;
  endfunction

  // One transaction; called at #1 after a rising edge. hold>0 back-pressures DONE.
  task automatic run_op(input vec_t v, input int hold, input string tag);
    int           lat;
    bit           ok;
    bit           rdy_seen;
    bit           stable;
    res_t         r;
    logic [W-1:0] held_sum;
    logic         held_cout;
    in_a = v.a;
    in_b = v.b;
    in_cin = v.cin;
`ifdef SUB_MODE_EN
    in_sub = v.sub;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk({tag, " accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{sum: v.sum, cout: v.cout});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    ok = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready || !busy) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk({tag, " result_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({tag, " latency"}, 64'(lat), 64'(NBYTES + 1));
    chk({tag, " run_in_ready_low"}, 64'(rdy_seen), 64'd0);
    if (hold > 0) begin
      held_sum  = out_sum;
      held_cout = out_cout;
      stable    = 1'b1;
      in_a      = ~v.a;
      in_b      = ~v.b;
      in_valid  = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!out_valid || out_sum !== held_sum || out_cout !== held_cout || in_ready || !busy)
          stable = 1'b0;
      end
      chk({tag, " done_hold_stable"}, 64'(stable), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    chk({tag, " done_in_ready"}, 64'(in_ready), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      r = sb.pop_front();
      chk({tag, " sum"}, 64'(out_sum), 64'(r.sum));
      chk({tag, " cout"}, 64'(out_cout), 64'(r.cout));
    end
    @(posedge clk); #1;
    chk({tag, " exit_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " exit_in_ready"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    res_t m;
    bit   seen;

    vecs.push_back('{a: 32'h12345678, b: 32'h11111111, cin: 1'b0, sub: 1'b0, sum: 32'h23456789, cout: 1'b0});
    vecs.push_back('{a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0, sum: 32'h00000000, cout: 1'b1});
    vecs.push_back('{a: 32'h00000000, b: 32'h00000000, cin: 1'b1, sub: 1'b0, sum: 32'h00000001, cout: 1'b0});
    vecs.push_back('{a: 32'h80000000, b: 32'h80000000, cin: 1'b0, sub: 1'b0, sum: 32'h00000000, cout: 1'b1});
    vecs.push_back('{a: 32'h000000FF, b: 32'h00000001, cin: 1'b0, sub: 1'b0, sum: 32'h00000100, cout: 1'b0});
    vecs.push_back('{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, cin: 1'b1, sub: 1'b0, sum: 32'hFFFFFFFF, cout: 1'b1});
    vecs.push_back('{a: 32'h00FF00FF, b: 32'h00010001, cin: 1'b0, sub: 1'b0, sum: 32'h01000100, cout: 1'b0});
    vecs.push_back('{a: 32'h7FFFFFFF, b: 32'h00000000, cin: 1'b1, sub: 1'b0, sum: 32'h80000000, cout: 1'b0});
`ifdef SUB_MODE_EN
    vecs.push_back('{a: 32'h00000005, b: 32'h00000007, cin: 1'b0, sub: 1'b1, sum: 32'hFFFFFFFE, cout: 1'b0});
    vecs.push_back('{a: 32'h00000007, b: 32'h00000005, cin: 1'b0, sub: 1'b1, sum: 32'h00000002, cout: 1'b1});
`endif
    for (int i = 0; i < 6; i++) begin
      v.a   = W'($urandom);
      v.b   = W'($urandom);
      v.cin = 1'($urandom_range(1));
`ifdef SUB_MODE_EN
      v.sub = 1'($urandom_range(1));
`else
      v.sub = 1'b0;
`endif
      m      = model(v.a, v.b, v.cin, v.sub);
      v.sum  = m.sum;
      v.cout = m.cout;
      vecs.push_back(v);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_sum", 64'(out_sum), 64'd0);
    chk("rst out_cout", 64'(out_cout), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Back-pressure: DONE held 6 cycles with a competing in_valid
    v = '{a: 32'hA5A5A5A5, b: 32'h5A5A5A5B, cin: 1'b0, sub: 1'b0, sum: 32'h00000000, cout: 1'b1};
    run_op(v, 6, "hold");

    // Reset on the second RUN cycle abandons the operation
    in_a = 32'h01020304;
    in_b = 32'h10203040;
    in_cin = 1'b0;
`ifdef SUB_MODE_EN
    in_sub = 1'b0;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("midrst pre_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midrst run_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_sum", 64'(out_sum), 64'd0);
    chk("midrst out_cout", 64'(out_cout), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    chk("midrst busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no_partial", 64'(seen), 64'd0);
    out_ready = 1'b0;

    // Operation right after the abandoned one still works
    v = '{a: 32'h0000FFFF, b: 32'h00000001, cin: 1'b1, sub: 1'b0, sum: 32'h00010001, cout: 1'b0};
    run_op(v, 0, "post_rst");

    chk("sb drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
